// File: rtl/hack_data_memory.sv
// hack_data_memory: Hack CPU data-memory responder.
// Maps general RAM (0x0000-0x3FFF), screen memory (0x4000-0x5FFF) with a
// frame scanner, and a FIFO-buffered keyboard register (0x6000).
// Optional macro HACK_MEM_KBD_STATUS_EN adds a keyboard status register at
// 0x6001 (FIFO count plus sticky overflow flag).
module hack_data_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] address,
  input  logic [15:0] data_in,
  input  logic        write,
  output logic [15:0] data_out,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic [15:0] pix_word,
  output logic        pix_valid,
  output logic        pix_last
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int KP_W   = $clog2(KBD_DEPTH);
  localparam int KC_W   = KP_W + 1;

  typedef enum logic {SCAN_IDLE, SCAN_RUN} scanState_t;

  logic [15:0] ramMem    [RAM_WORDS];
  logic [15:0] screenMem [SCREEN_WORDS];
  logic [15:0] kbdMem    [KBD_DEPTH];

  logic ramSel, scrSel, kbdSel;

  logic [KP_W-1:0] kbdWrPtr_q, kbdWrPtr_d;
  logic [KP_W-1:0] kbdRdPtr_q, kbdRdPtr_d;
  logic [KC_W-1:0] kbdCount_q, kbdCount_d;
  logic            kbdFull, kbdEmpty, kbdPush, kbdPop;

  scanState_t        scanState_q;
  logic [SCR_AW-1:0] scanIdx_q;
  logic              scanBusy_q;
  logic [15:0]       pixWord_q;
  logic              pixValid_q;
  logic              pixLast_q;

  // The memory map only needs the top address bits plus exact KBD match.
  assign ramSel = (address[14] == 1'b0);
  assign scrSel = (address[14:13] == 2'b10);
  assign kbdSel = (address == 15'h6000);

  assign kbdFull   = (kbdCount_q == KC_W'(KBD_DEPTH));
  assign kbdEmpty  = (kbdCount_q == '0);
  assign kbdPush   = kbd_valid && !kbdFull;
  assign kbdPop    = write && kbdSel && !kbdEmpty;
  assign kbd_ready = !kbdFull;

  assign scan_busy = scanBusy_q;
  assign pix_word  = pixWord_q;
  assign pix_valid = pixValid_q;
  assign pix_last  = pixLast_q;

  // General RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (write && ramSel) begin
      ramMem[address[RAM_AW-1:0]] <= data_in;
    end
  end

  // Screen write port; the scanner reads the pre-edge value on a collision.
  always_ff @(posedge clock) begin
    if (write && scrSel) begin
      screenMem[address[SCR_AW-1:0]] <= data_in;
    end
  end

  // Keyboard FIFO storage; only pointers and count need reset.
  always_ff @(posedge clock) begin
    if (kbdPush) begin
      kbdMem[kbdWrPtr_q] <= kbd_code;
    end
  end

  // FIFO next state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    kbdWrPtr_d = kbdWrPtr_q;
    kbdRdPtr_d = kbdRdPtr_q;
    kbdCount_d = kbdCount_q;
    if (kbdPush) begin
      kbdWrPtr_d = kbdWrPtr_q + KP_W'(1);
    end
    if (kbdPop) begin
      kbdRdPtr_d = kbdRdPtr_q + KP_W'(1);
    end
    if (kbdPush && !kbdPop) begin
      kbdCount_d = kbdCount_q + KC_W'(1);
    end else if (kbdPop && !kbdPush) begin
      kbdCount_d = kbdCount_q - KC_W'(1);
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kbdWrPtr_q <= '0;
      kbdRdPtr_q <= '0;
      kbdCount_q <= '0;
    end else begin
      kbdWrPtr_q <= kbdWrPtr_d;
      kbdRdPtr_q <= kbdRdPtr_d;
      kbdCount_q <= kbdCount_d;
    end
  end

`ifdef HACK_MEM_KBD_STATUS_EN
  logic statSel;
  logic kbdOverflow_q, kbdOverflow_d;

  assign statSel = (address == 15'h6001);

  // Sticky overflow: a new overflow beats a simultaneous software clear.
  always_comb begin
    kbdOverflow_d = kbdOverflow_q;
    if (kbd_valid && kbdFull) begin
      kbdOverflow_d = 1'b1;
    end else if (write && statSel) begin
      kbdOverflow_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kbdOverflow_q <= 1'b0;
    end else begin
      kbdOverflow_q <= kbdOverflow_d;
    end
  end
`endif

  // Zero-latency read mux; anything unmapped reads as zero.
  always_comb begin
    data_out = '0;
    if (ramSel) begin
      data_out = ramMem[address[RAM_AW-1:0]];
    end else if (scrSel) begin
      data_out = screenMem[address[SCR_AW-1:0]];
    end else if (kbdSel) begin
      data_out = kbdEmpty ? 16'h0000 : kbdMem[kbdRdPtr_q];
`ifdef HACK_MEM_KBD_STATUS_EN
    end else if (statSel) begin
      data_out = {kbdOverflow_q, 7'b0, 8'(kbdCount_q)};
`endif
    end
  end

  // Frame scanner: one screen word per cycle, outputs registered one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scanState_q <= SCAN_IDLE;
      scanIdx_q   <= '0;
      scanBusy_q  <= 1'b0;
      pixWord_q   <= '0;
      pixValid_q  <= 1'b0;
      pixLast_q   <= 1'b0;
    end else begin
      case (scanState_q)
        SCAN_IDLE: begin
          pixValid_q <= 1'b0;
          pixLast_q  <= 1'b0;
          if (scan_start) begin
            scanState_q <= SCAN_RUN;
            scanIdx_q   <= '0;
            scanBusy_q  <= 1'b1;
          end
        end
        SCAN_RUN: begin
          pixWord_q  <= screenMem[scanIdx_q];
          pixValid_q <= 1'b1;
          pixLast_q  <= (scanIdx_q == SCR_AW'(SCREEN_WORDS - 1));
          if (scanIdx_q == SCR_AW'(SCREEN_WORDS - 1)) begin
            scanState_q <= SCAN_IDLE;
            scanBusy_q  <= 1'b0;
          end else begin
            scanIdx_q <= scanIdx_q + SCR_AW'(1);
          end
        end
        default: begin
          scanState_q <= SCAN_IDLE;
          scanBusy_q  <= 1'b0;
          pixValid_q  <= 1'b0;
          pixLast_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory responder for the Hack CPU: serves the CPU's (address, write data, write enable) port and returns read data in the same cycle.
- Decodes the Hack memory map into three regions:
  - general RAM;
  - screen memory, with a built-in frame scanner that streams it to a display;
  - a buffered keyboard register fed by a valid/ready key source.
- Sits between the CPU's data port and the top-level I/O.

Parameters:
- RAM_WORDS, 16384, general RAM depth at 0x0000-0x3FFF.
- SCREEN_WORDS, 8192, screen depth at 0x4000-0x5FFF; also the scanner frame length.
- KBD_DEPTH, 4, keyboard FIFO entries (power of two, >=2).

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  15  word address from CPU.
- data_in  in  16  CPU write data.
- write  in  1  CPU write enable.
- data_out  out  16  read data to CPU, combinational from address.
- kbd_code  in  16  key code from keyboard source.
- kbd_valid  in  1  kbd_code valid.
- kbd_ready  out  1  FIFO can accept; a push occurs when kbd_valid & kbd_ready.
- scan_start  in  1  request one full screen scan.
- scan_busy  out  1  scanner active.
- pix_word  out  16  scanned screen word.
- pix_valid  out  1  pix_word valid this cycle.
- pix_last  out  1  with pix_valid, marks final word of frame.

Behaviour:
- Reset (async, active-high) clears:
  - FIFO pointers and count (empty, kbd_ready=1);
  - scanner state to IDLE, scan_busy=0, pix_valid=0, pix_last=0, pix_word=0.
- RAM and screen arrays are not cleared.
- Decode:
  - 0x0000-0x3FFF: RAM.
  - 0x4000-0x5FFF: screen.
  - 0x6000: KBD.
  - 0x6001-0x7FFF: unmapped; reads return 0, writes are ignored.
- Reads: data_out is combinational with zero latency; a CPU load completes in the same cycle.
- Writes: RAM/screen are written on the rising edge when write=1; the new value is visible to reads from the next cycle.
- KBD read: returns the FIFO head, or 0x0000 when the FIFO is empty.
- KBD write (any data_in value): pops the head; no effect when empty.
- FIFO rules:
  - kbd_ready = !full, derived from the registered count.
  - Push and pop in the same cycle when non-empty and non-full: count unchanged, ordering preserved.
  - Full: push refused even if a pop occurs that cycle.
  - Empty with simultaneous push and pop: the pop is ignored and the push is stored.
  - Pointers wrap modulo KBD_DEPTH.
- Scanner FSM:
  - IDLE: scan_start=1 moves to SCAN with index=0 and scan_busy=1 on the next cycle.
  - SCAN: each cycle reads screen[index] and increments index.
  - Output timing: pix_word/pix_valid are registered, 1 cycle after the read; pix_last is asserted with the word at index SCAN_WORDS-1.
  - After that final read the FSM returns to IDLE. scan_busy drops in the same cycle pix_last is asserted.
  - scan_start during SCAN is ignored.
  - Read-before-write: a CPU write to the word being scanned in the same cycle yields the old value on pix_word.
  - pix_word holds its last value when pix_valid=0.
- Reset mid-scan: immediately IDLE with pix_valid=0, pix_last=0. Reset mid-FIFO: all queued keys are discarded.

Optional Feature:
- Macro: HACK_MEM_KBD_STATUS_EN.
- Defined:
  - Address 0x6001 becomes the KBD status register.
  - Read value: bits[7:0] = FIFO count, bit15 = sticky overflow flag, other bits 0.
  - The overflow flag sets whenever kbd_valid=1 while full.
  - Any write to 0x6001 clears the flag; if an overflow occurs in the same cycle as the clear, set wins.
  - Reset clears the flag.
- Not defined: 0x6001 is unmapped (reads 0, writes ignored) and no overflow logic is synthesized.

Test Plan:
- Write 0x1234 to 0x0005, then read 0x0005 → data_out=0x1234 the following cycle. Write 0xFFFF to 0x6005 → read returns 0x0000.
- Push 0x0041, 0x0042 via kbd_valid → read 0x6000=0x0041; write 0x6000 → read=0x0042; pop again → 0x0000 and kbd_ready=1.
- Push 5 codes with KBD_DEPTH=4 → kbd_ready=0 after the 4th and the 5th is not accepted. Simultaneous pop + push while full → only the pop occurs, count=3. With HACK_MEM_KBD_STATUS_EN, 0x6001 reads 0x8004 before the pop.
- Fill the screen with word=index, pulse scan_start → 8192 pix_valid words 0x0000..0x1FFF in order, pix_last only on 0x1FFF, scan_busy low afterward. A second scan_start mid-scan has no effect.
- During a scan, the CPU writes 0xAAAA to the word being read that same cycle → pix_word shows the old value. The next frame shows 0xAAAA.
- Assert reset mid-scan with 2 keys queued → pix_valid=0 and scan_busy=0 immediately, KBD reads 0x0000, kbd_ready=1.
